// File: rtl/ltc2378_pkg.sv
// Shared definitions for the LTC2378 slave emulator and its master-side users.
package ltc2378_pkg;

    localparam int LTC_DATA_W = 20;

    // Full-scale codes; the master's overload check compares against these.
    localparam logic [LTC_DATA_W-1:0] LTC_FS_POS = 20'h7FFFF;
    localparam logic [LTC_DATA_W-1:0] LTC_FS_NEG = 20'h80000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2
    } ltc_state_e;

endpackage

// File: rtl/ltc2378_emulator_edge_sync.sv
// Synchronizes an asynchronous input and emits a registered one-cycle pulse on
// each rising edge.
module edge_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   hist_q, hist_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_d};
        hist_d = sync_q[SYNC_STAGES-1];
        rise_d = sync_q[SYNC_STAGES-1] & ~hist_q;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync_q <= '0;
            hist_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
            rise_q <= rise_d;
        end
    end

    assign o_rise = rise_q;

endmodule

// File: rtl/ltc2378_emulator.sv
// Slave-side model of the LTC2378 serial interface: CNV starts a conversion,
// BUSY is held for CONV_CYCLES, then SCK rises shift the sample out on SDO.
module ltc2378_emulator
    import ltc2378_pkg::*;
#(
    parameter int DATA_W      = LTC_DATA_W,
    parameter int CONV_CYCLES = 130,
    parameter int SYNC_STAGES = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cnv,
    input  logic              i_sck,
    output logic              o_busy,
    output logic              o_sdo,
    input  logic [DATA_W-1:0] i_sample,
    input  logic              i_sample_valid,
    output logic              o_sample_ready,
    output logic              o_underrun,
    output logic              o_proto_err,
    input  logic              i_clr_err
);

    localparam int CNT_W = $clog2(CONV_CYCLES + 1);
    localparam int BIT_W = $clog2(DATA_W);

    logic cnv_rise, sck_rise;

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_cnv_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_cnv),
        .o_rise (cnv_rise)
    );

    edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_sck),
        .o_rise (sck_rise)
    );

    ltc_state_e        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [DATA_W-1:0] held_q, held_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic              busy_q, busy_d;
    logic              sdo_q, sdo_d;
    logic              ready_q, ready_d;
    logic              underrun_q, underrun_d;
    logic              proto_q, proto_d;

    logic              accept;
    logic [DATA_W-1:0] load_val;

    // CNV outside a conversion (IDLE, or aborting a partial readout) starts a new one.
    assign accept   = cnv_rise && (state_q != CONV);
    assign load_val = i_sample_valid ? i_sample : held_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        held_d     = held_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        busy_d     = busy_q;
        sdo_d      = sdo_q;
        ready_d    = 1'b0;
        underrun_d = (underrun_q & ~i_clr_err) | (accept & ~i_sample_valid);
        proto_d    = (proto_q & ~i_clr_err) |
                     ((state_q == CONV) & (cnv_rise | sck_rise));

        if (accept) begin
            shift_d = load_val;
            held_d  = load_val;
            ready_d = i_sample_valid;
            busy_d  = 1'b1;
            sdo_d   = 1'b0;
            cnt_d   = CNT_W'(CONV_CYCLES - 1);
            state_d = CONV;
        end else begin
            case (state_q)
                CONV: begin
                    if (cnt_q == '0) begin
                        busy_d  = 1'b0;
                        sdo_d   = shift_q[DATA_W-1];
                        bit_d   = BIT_W'(DATA_W - 1);
                        state_d = SHIFT;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                SHIFT: begin
                    if (sck_rise) begin
                        shift_d = {shift_q[DATA_W-2:0], 1'b0};
                        if (bit_q == '0) begin
                            sdo_d   = 1'b0;
                            state_d = IDLE;
                        end else begin
                            sdo_d = shift_q[DATA_W-2];
                            bit_d = bit_q - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            held_q     <= '0;
            cnt_q      <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b0;
            sdo_q      <= 1'b0;
            ready_q    <= 1'b0;
            underrun_q <= 1'b0;
            proto_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            held_q     <= held_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            sdo_q      <= sdo_d;
            ready_q    <= ready_d;
            underrun_q <= underrun_d;
            proto_q    <= proto_d;
        end
    end

    assign o_busy         = busy_q;
    assign o_sdo          = sdo_q;
    assign o_sample_ready = ready_q;
    assign o_underrun     = underrun_q;
    assign o_proto_err    = proto_q;

endmodule
